// File: rtl/rx_deframer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rx_deframer_pkg
//  Description : Shared types and constants for the rx deframer slice.
//                The header word layout is {opcode[7:0], len[23:0]}. The
//                opcode values are listed for the downstream loaders; the
//                deframer itself forwards the opcode without interpreting it.
//  Revision    : 1.0  initial release
// ============================================================================
package rx_deframer_pkg;

  localparam int RX_WORD_W = 32;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] len;
  } rx_header_t;

  typedef enum logic [7:0] {
    LOAD_WEIGHTS = 8'h00,
    LOAD_INPUTS  = 8'h01,
    RUN          = 8'h02,
    READBACK     = 8'h03
  } rx_opcode_e;

  // Reinterpret a raw stream word as a packet header.
  function automatic rx_header_t rx_unpack_hdr(input logic [RX_WORD_W-1:0] i_word);
    return rx_header_t'(i_word);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_skid2.sv
`default_nettype none
// ============================================================================
//  Module      : rx_skid2
//  Description : Two-entry skid buffer that absorbs the one-cycle read
//                latency of a non-showahead FIFO. A push and a pop in the
//                same cycle leave the occupancy unchanged.
//  Ports       : clk, reset    - clock, synchronous active-high reset
//                i_push/i_data - write one word
//                i_pop         - drop the head word (only when non-empty)
//                o_data        - head word
//                o_count       - occupancy (0..2)
//  Revision    : 1.0  initial release
// ============================================================================
module rx_skid2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  // Storage is not reset: an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : rx_deframer
//  Description : Splits the host-to-FPGA 32-bit word stream read from the
//                PCIe rx FIFO into packets (one header word + len payload
//                words). Each packet yields one command record on the cmd
//                handshake, then its payload on a valid/ready stream with a
//                last flag. Oversize packets are dropped and flagged.
//  Option      : RX_DEFRAMER_CHECKSUM_EN - every packet with len > 0 carries
//                a trailer word (sum mod 2^32 of the payload); a mismatch
//                sets the sticky err_chk output.
//  Ports       : clk, reset               - bus clock, sync active-high reset
//                rx_rdreq/rx_empty/rx_q   - rx FIFO read side (non-showahead)
//                cmd_valid/cmd_ready      - command handshake
//                cmd_opcode/cmd_len       - header fields of current packet
//                pl_valid/pl_ready        - payload handshake
//                pl_data/pl_last          - payload word and end-of-packet
//                err_len                  - sticky oversize-header flag
//                err_chk                  - sticky checksum flag (option only)
//                pkt_count                - packets fully consumed (wrapping)
//  Revision    : 1.0  initial release
// ============================================================================
module rx_deframer
  import rx_deframer_pkg::*;
#(
  parameter int MAX_LEN = 4096,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 rx_rdreq,
  input  logic                 rx_empty,
  input  logic [RX_WORD_W-1:0] rx_q,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [7:0]           cmd_opcode,
  output logic [23:0]          cmd_len,
  output logic                 pl_valid,
  input  logic                 pl_ready,
  output logic [RX_WORD_W-1:0] pl_data,
  output logic                 pl_last,
  output logic                 err_len,
`ifdef RX_DEFRAMER_CHECKSUM_EN
  output logic                 err_chk,
`endif
  output logic [CNT_W-1:0]     pkt_count
);

  localparam logic [2:0] S_HDR   = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_PAY   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
`ifdef RX_DEFRAMER_CHECKSUM_EN
  localparam logic [2:0] S_CHK   = 3'd4;
`endif

  localparam logic [24:0]      C_MAX_LEN = 25'(MAX_LEN);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  // --------------------------------------------------------------------
  // FIFO front end and skid buffer
  // --------------------------------------------------------------------
  logic                 r_inflight;
  logic [1:0]           w_skid_cnt;
  logic [RX_WORD_W-1:0] w_skid_head;
  logic                 w_skid_nempty;
  logic                 w_pop;
  logic [2:0]           w_pending;

  rx_skid2 #(
    .W (RX_WORD_W)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_inflight),
    .i_data  (rx_q),
    .i_pop   (w_pop),
    .o_data  (w_skid_head),
    .o_count (w_skid_cnt)
  );

  assign w_skid_nempty = (w_skid_cnt != 2'd0);

  // Occupancy is counted after this cycle's pop. Counting it before the
  // pop would stall the FIFO every other word while a consumer is draining
  // at full rate; after-pop accounting still never exceeds two entries.
  assign w_pending = 3'(w_skid_cnt) - 3'(w_pop) + 3'(r_inflight);
  assign rx_rdreq  = !reset && !rx_empty && (w_pending < 3'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= rx_rdreq;
    end
  end

  // --------------------------------------------------------------------
  // Packet state machine
  // --------------------------------------------------------------------
  logic [2:0]       r_state;
  logic [24:0]      r_remaining;
  logic [7:0]       r_opcode;
  logic [23:0]      r_len;
  logic             r_err_len;
  logic [CNT_W-1:0] r_pkt_count;
`ifdef RX_DEFRAMER_CHECKSUM_EN
  logic [RX_WORD_W-1:0] r_csum;
  logic                 r_err_chk;
`endif

  rx_header_t w_hdr;
  logic       w_len_bad;
  logic       w_last;
  logic       w_pl_accept;

  assign w_hdr       = rx_unpack_hdr(w_skid_head);
  assign w_len_bad   = ({1'b0, w_hdr.len} > C_MAX_LEN);
  assign w_last      = (r_remaining == 25'd1);
  assign w_pl_accept = (r_state == S_PAY) && w_skid_nempty && pl_ready;

  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      S_HDR:   w_pop = w_skid_nempty;
      S_PAY:   w_pop = w_pl_accept;
      S_DRAIN: w_pop = w_skid_nempty && (r_remaining != 25'd0);
`ifdef RX_DEFRAMER_CHECKSUM_EN
      S_CHK:   w_pop = w_skid_nempty;
`endif
      default: w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_HDR;
      r_remaining <= 25'd0;
      r_opcode    <= 8'd0;
      r_len       <= 24'd0;
      r_err_len   <= 1'b0;
      r_pkt_count <= '0;
`ifdef RX_DEFRAMER_CHECKSUM_EN
      r_csum      <= '0;
      r_err_chk   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_HDR: begin
          if (w_skid_nempty) begin
            if (w_len_bad) begin
              r_err_len <= 1'b1;
`ifdef RX_DEFRAMER_CHECKSUM_EN
              // Dropped packets still carry their trailer word.
              r_remaining <= {1'b0, w_hdr.len} + 25'd1;
`else
              r_remaining <= {1'b0, w_hdr.len};
`endif
              r_state <= S_DRAIN;
            end else begin
              r_opcode <= w_hdr.opcode;
              r_len    <= w_hdr.len;
              r_state  <= S_CMD;
            end
          end
        end

        S_CMD: begin
          if (cmd_ready) begin
            if (r_len == 24'd0) begin
              r_pkt_count <= r_pkt_count + C_CNT_ONE;
              r_state     <= S_HDR;
            end else begin
              r_remaining <= {1'b0, r_len};
`ifdef RX_DEFRAMER_CHECKSUM_EN
              r_csum      <= '0;
`endif
              r_state     <= S_PAY;
            end
          end
        end

        S_PAY: begin
          if (w_pl_accept) begin
            r_remaining <= r_remaining - 25'd1;
`ifdef RX_DEFRAMER_CHECKSUM_EN
            r_csum      <= r_csum + w_skid_head;
            if (w_last) begin
              r_state <= S_CHK;
            end
`else
            if (w_last) begin
              r_pkt_count <= r_pkt_count + C_CNT_ONE;
              r_state     <= S_HDR;
            end
`endif
          end
        end

`ifdef RX_DEFRAMER_CHECKSUM_EN
        S_CHK: begin
          if (w_skid_nempty) begin
            if (w_skid_head != r_csum) begin
              r_err_chk <= 1'b1;
            end
            r_pkt_count <= r_pkt_count + C_CNT_ONE;
            r_state     <= S_HDR;
          end
        end
`endif

        S_DRAIN: begin
          if (r_remaining == 25'd0) begin
            r_state <= S_HDR;
          end else if (w_skid_nempty) begin
            r_remaining <= r_remaining - 25'd1;
            // Leave as soon as the final dropped word is consumed so the
            // following header is not delayed by an extra idle cycle.
            if (w_last) begin
              r_state <= S_HDR;
            end
          end
        end

        default: r_state <= S_HDR;
      endcase
    end
  end

  // --------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------
  assign cmd_valid  = (r_state == S_CMD);
  assign cmd_opcode = r_opcode;
  assign cmd_len    = r_len;

  assign pl_valid = (r_state == S_PAY) && w_skid_nempty;
  // Data is zeroed while idle so nothing stale from the skid leaks out.
  assign pl_data  = pl_valid ? w_skid_head : '0;
  assign pl_last  = pl_valid && w_last;

  assign err_len   = r_err_len;
  assign pkt_count = r_pkt_count;
`ifdef RX_DEFRAMER_CHECKSUM_EN
  assign err_chk   = r_err_chk;
`endif

endmodule
`default_nettype wire
